// File: rtl/stoch_decode_mat.sv
// Stochastic matrix decoder: counts ones per element over 2^WIN_LOG2 accepted samples and
// presents saturated unsigned words behind a one-deep valid/ready output buffer.
//   state    | meaning
//   ST_ACCUM | accepting samples into the element counters
//   ST_FULL  | a finished window waits in the counters behind a held result; input stalled
module stoch_decode_mat #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3,
    parameter int WIN_LOG2 = 8
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   CLR,
    input  logic [NUM_ROWS*NUM_COLS-1:0]           X,
    input  logic                                   X_VALID,
    output logic                                   X_READY,
    output logic [NUM_ROWS*NUM_COLS*WIN_LOG2-1:0]  Y,
    output logic                                   Y_VALID,
    input  logic                                   Y_READY
);
    localparam int N = NUM_ROWS * NUM_COLS;
    localparam int W = WIN_LOG2;

    typedef enum logic {ST_ACCUM, ST_FULL} state_e;

    state_e           state_q, state_d;
    logic [W:0]       cnt_q [N];
    logic [W:0]       cnt_d [N];
    logic [W:0]       cnt_inc [N];
    logic [W-1:0]     samp_q, samp_d;
    logic [N*W-1:0]   y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             beat, handoff, win_done, load_win, load_full;

    function automatic logic [W-1:0] sat(input logic [W:0] n);
        return n[W] ? {W{1'b1}} : n[W-1:0];
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_ACCUM;
            samp_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < N; k++) cnt_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (!CLR && win_done && y_valid_q && !Y_READY) state_d = ST_FULL;
            ST_FULL:  if (CLR || handoff) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        X_READY = (state_q == ST_ACCUM);
        Y       = y_q;
        Y_VALID = y_valid_q;
    end

    assign beat      = X_VALID & X_READY;
    assign handoff   = y_valid_q & Y_READY;
    assign win_done  = beat & (samp_q == {W{1'b1}});
    assign load_win  = !CLR && win_done && (!y_valid_q || Y_READY);
    assign load_full = !CLR && (state_q == ST_FULL) && handoff;

    always_comb begin
        for (int k = 0; k < N; k++) cnt_inc[k] = cnt_q[k] + (W+1)'(X[k]);
    end

    // A load of a new result overrides the valid drop caused by a handoff.
    always_comb begin
        samp_d    = samp_q;
        y_d       = y_q;
        y_valid_d = handoff ? 1'b0 : y_valid_q;
        for (int k = 0; k < N; k++) cnt_d[k] = cnt_q[k];
        if (CLR) begin
            samp_d = '0;
            for (int k = 0; k < N; k++) cnt_d[k] = '0;
        end else if (load_full) begin
            y_valid_d = 1'b1;
            samp_d    = '0;
            for (int k = 0; k < N; k++) begin
                y_d[k*W +: W] = sat(cnt_q[k]);
                cnt_d[k]      = '0;
            end
        end else if (beat) begin
            samp_d = samp_q + W'(1);
            if (load_win) begin
                y_valid_d = 1'b1;
                for (int k = 0; k < N; k++) begin
                    y_d[k*W +: W] = sat(cnt_inc[k]);
                    cnt_d[k]      = '0;
                end
            end else begin
                for (int k = 0; k < N; k++) cnt_d[k] = cnt_inc[k];
            end
        end
    end
endmodule
